ls_arbiter: RTL and testbench
=============================

# ls_arbiter

Parametrised local-store arbiter that lets NUM_CH requesters share one single-port SPE memory. Typical requesters are instruction-cache refill, SPU load/store and a DMA engine. Each cycle the block grants one request, drives the memory port registered, and routes each read's data back to its requester after the memory's fixed latency. It sits between the SPU/cache side and the memory inside the SPE top and replaces direct point-to-point wiring to the memory.

## Interface
- NUM_CH, 3, number of requester channels (2..8)
- ADDR_W, 32, address width
- DATA_W, 128, data width
- MEM_LAT, 2, cycles from mem_en_o high to mem_rdata_i valid (1..4)
- MAX_LOCK, 16, maximum consecutive locked grants to one channel
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_i  in  NUM_CH  per-channel request, held until granted
- we_i  in  NUM_CH  per-channel write (1) / read (0)
- lock_i  in  NUM_CH  keep the grant on this channel after the current beat
- addr_i  in  NUM_CH*ADDR_W  flattened addresses, channel 0 in the LSBs
- wdata_i  in  NUM_CH*DATA_W  flattened write data
- gnt_o  out  NUM_CH  one-hot grant, combinational, this cycle's request accepted
- rvalid_o  out  NUM_CH  one-hot read-data valid
- rdata_o  out  DATA_W  read data (pass-through of mem_rdata_i)
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data

## Operation
**Handshake**
- A requester holds req_i and its payload stable until it sees gnt_o high in the same cycle.
- The request is consumed on that clock edge. At most one gnt_o bit is high per cycle.
- A channel may request every cycle. A back-to-back winner gets a grant every cycle, so there are no bubbles.

**Arbitration (default round-robin)**
- Search starts at rr_ptr and wraps modulo NUM_CH.
- After a grant to channel c, rr_ptr ← (c+1) mod NUM_CH.

**State machine**
- IDLE → LOCKED: when the granted channel c has lock_i[c]=1. Set lock_ch=c and lock_cnt=1.
- LOCKED: only lock_ch can be granted; other requests wait. Each grant increments lock_cnt.
- LOCKED → IDLE, when any of these holds:
  - lock_i[lock_ch]=0 at a grant;
  - req_i[lock_ch]=0 for a cycle (no grant that cycle);
  - lock_cnt reaches MAX_LOCK. This is a forced release: rr_ptr ← lock_ch+1, so another channel wins next if it is requesting.

**Memory side**
- mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o are registered from the winner's payload.
- When there is no grant, mem_en_o=0 and mem_we_o=0.

**Return path**
- A MEM_LAT-deep shift register of {valid, channel id} is loaded with valid=1 only for read grants.
- In cycle M+MEM_LAT (where M is the mem_en_o cycle): rvalid_o[id]=1 and rdata_o=mem_rdata_i.
- Writes produce no rvalid_o.

## Timing
- Grant in cycle N → memory access in cycle N+1 → read data in cycle N+1+MEM_LAT.
- Throughput: one access per cycle.
- Reset values: gnt_o=0, rvalid_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rr_ptr=0, state=IDLE, lock_cnt=0, tag pipe all invalid.
- Reset mid-operation:
  - In-flight reads are discarded; rvalid_o never fires for them.
  - gnt_o is forced low while rst=1.
- Simultaneous request on every channel: exactly one grant. With continuous requests, channels are served in cyclic order.
- A request arriving in the same cycle its channel is at rr_ptr is granted that cycle (zero-wait).
- lock_i is ignored on write-versus-read distinction: locks apply to both.
- lock_i on a cycle without a grant has no effect.
- rdata_o is undefined when no rvalid_o bit is set.

## Configuration
- ARB_FIXED_PRIO_EN
  - Defined: fixed priority; lowest-index requesting channel wins, and rr_ptr is not used. Lock and MAX_LOCK behaviour is unchanged. A forced release grants the highest-priority other requester for one cycle before channel lock_ch may win again.
  - Undefined: round-robin as above.

## Test plan
Parameters for all scenarios: NUM_CH=3, MEM_LAT=2, MAX_LOCK=4.
- **Single read:** ch1 read addr 0x40 at cycle 5 → gnt_o=010 at cycle 5, mem_en_o=1 with mem_addr_o=0x40 at cycle 6; with mem_rdata_i=0xA5 at cycle 8, rvalid_o=010 and rdata_o=0xA5.
- **All channels request continuously from reset:** grants are 001, 010, 100, 001… with no idle cycle. With ARB_FIXED_PRIO_EN defined, grants are 001 every cycle.
- **Lock burst:** ch0 holds lock_i for 4 reads while ch2 requests → ch0 granted 4 times (forced release at MAX_LOCK=4), ch2 granted on the 5th cycle.
- **Mixed traffic:** ch0 write and ch1 read back-to-back → mem_we_o=1 then 0. Only rvalid_o=010 appears, 3 cycles after ch1's grant; no rvalid for ch0.
- **Reset mid-flight:** rst asserted one cycle after a read grant → rvalid_o stays 0 through cycle N+4, and after release the next grant starts from rr_ptr=0.
- **Lock drop:** lock_i dropped by ch0 on its 2nd locked beat → state returns to IDLE; pending ch1 granted next cycle.

Source files
------------

// File: rtl/ls_arbiter.sv
// ls_arbiter: NUM_CH requesters sharing one single-port local-store memory, with a tagged read-return pipe.
// Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module ls_arbiter #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int MEM_LAT  = 2,
    parameter int MAX_LOCK = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH-1:0]        we_i,
    input  logic [NUM_CH-1:0]        lock_i,
    input  logic [NUM_CH*ADDR_W-1:0] addr_i,
    input  logic [NUM_CH*DATA_W-1:0] wdata_i,
    output logic [NUM_CH-1:0]        gnt_o,
    output logic [NUM_CH-1:0]        rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic [DATA_W-1:0]        mem_rdata_i
);
    // state  | meaning
    // IDLE   | open arbitration among all requesters
    // LOCKED | only the channel in lock_oh may be granted
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [NUM_CH-1:0]   lock_oh;
    logic [CNT_W-1:0]    lock_cnt;
`ifdef ARB_FIXED_PRIO_EN
    logic [NUM_CH-1:0]   excl_oh;
`else
    logic [CH_W-1:0]     rr_ptr;
`endif

    logic [NUM_CH-1:0]   gnt;
    logic                found;
    logic                gnt_any;
    logic                gnt_we;
    logic                gnt_lock;
    logic [CH_W-1:0]     gnt_idx;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;

    logic                mem_rd_vld;
    logic [CH_W-1:0]     mem_rd_id;
    logic [MEM_LAT-1:0]  tag_vld;
    logic [CH_W-1:0]     tag_id [MEM_LAT];

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (state == LOCKED) begin
            gnt = req_i & lock_oh;
        end else begin
`ifdef ARB_FIXED_PRIO_EN
            for (int c = 0; c < NUM_CH; c++) begin
                if (!found && req_i[c] && !excl_oh[c]) begin
                    gnt[c] = 1'b1;
                    found  = 1'b1;
                end
            end
`else
            // walk offsets from rr_ptr; first requester at the smallest offset wins
            for (int i = 0; i < NUM_CH; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!found && req_i[c] && c == (int'(rr_ptr) + i) % NUM_CH) begin
                        gnt[c] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
`endif
        end
        if (rst) gnt = '0;
    end

    always_comb begin
        gnt_idx   = '0;
        gnt_we    = 1'b0;
        gnt_lock  = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt[c]) begin
                gnt_idx   = CH_W'(c);
                gnt_we    = we_i[c];
                gnt_lock  = lock_i[c];
                gnt_addr  = addr_i[c*ADDR_W +: ADDR_W];
                gnt_wdata = wdata_i[c*DATA_W +: DATA_W];
            end
        end
    end

    assign gnt_any = |gnt;
    assign gnt_o   = gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lock_oh     <= '0;
            lock_cnt    <= '0;
`ifdef ARB_FIXED_PRIO_EN
            excl_oh     <= '0;
`else
            rr_ptr      <= '0;
`endif
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_rd_vld  <= 1'b0;
            mem_rd_id   <= '0;
        end else begin
            mem_en_o   <= gnt_any;
            mem_we_o   <= gnt_any & gnt_we;
            mem_rd_vld <= gnt_any & ~gnt_we;
            if (gnt_any) begin
                mem_addr_o  <= gnt_addr;
                mem_wdata_o <= gnt_wdata;
                mem_rd_id   <= gnt_idx;
`ifndef ARB_FIXED_PRIO_EN
                rr_ptr      <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
`endif
            end
`ifdef ARB_FIXED_PRIO_EN
            excl_oh <= '0;
`endif
            case (state)
                IDLE: begin
                    if (gnt_any && gnt_lock) begin
                        if (MAX_LOCK > 1) begin
                            state    <= LOCKED;
                            lock_oh  <= gnt;
                            lock_cnt <= CNT_W'(1);
                        end
`ifdef ARB_FIXED_PRIO_EN
                        else excl_oh <= gnt;
`endif
                    end
                end
                LOCKED: begin
                    if (!gnt_any || !gnt_lock) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (int'(lock_cnt) + 1 >= MAX_LOCK) begin
                        // forced release: the holder steps aside for one arbitration
                        state    <= IDLE;
                        lock_cnt <= '0;
`ifdef ARB_FIXED_PRIO_EN
                        excl_oh  <= lock_oh;
`endif
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int k = 0; k < MEM_LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_vld[0] <= mem_rd_vld;
            tag_id[0]  <= mem_rd_id;
            for (int k = 1; k < MEM_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (tag_vld[MEM_LAT-1] && tag_id[MEM_LAT-1] == CH_W'(c)) rvalid_o[c] = 1'b1;
        end
    end

    assign rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_ls_arbiter.sv
// Self-checking bench for ls_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_ls_arbiter;
    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MEM_LAT  = 2;
    localparam int MAX_LOCK = 4;
    localparam int N_RAND   = 600;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_CH-1:0]        req_i = '0;
    logic [NUM_CH-1:0]        we_i = '0;
    logic [NUM_CH-1:0]        lock_i = '0;
    logic [NUM_CH*ADDR_W-1:0] addr_i = '0;
    logic [NUM_CH*DATA_W-1:0] wdata_i = '0;
    logic [NUM_CH-1:0]        gnt_o;
    logic [NUM_CH-1:0]        rvalid_o;
    logic [DATA_W-1:0]        rdata_o;
    logic                     mem_en_o;
    logic                     mem_we_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [DATA_W-1:0]        mem_wdata_o;
    logic [DATA_W-1:0]        mem_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    ls_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                 .MEM_LAT(MEM_LAT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i  = '0;
        we_i   = '0;
        lock_i = '0;
    endtask

    task automatic set_ch(input int c, input logic we, input logic lk,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_i[c]                     = 1'b1;
        we_i[c]                      = we;
        lock_i[c]                    = lk;
        addr_i[c*ADDR_W +: ADDR_W]   = a;
        wdata_i[c*DATA_W +: DATA_W]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req_i  = '1;
        lock_i = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt_o); end
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", rvalid_o); end
        checks++; if (mem_en_o !== 1'b0 || mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we got %b%b exp 00", mem_en_o, mem_we_o); end
        checks++; if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin errors++; $display("FAIL reset_mem_payload got %h/%h exp 0/0", mem_addr_o, mem_wdata_o); end
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_ch(1, 1'b0, 1'b0, 16'h0040, '0);
        @(negedge clk);
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL single_gnt got %b exp 010", gnt_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 16'h0040) begin
            errors++; $display("FAIL single_mem got en=%b we=%b addr=%h exp en=1 we=0 addr=0040", mem_en_o, mem_we_o, mem_addr_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL single_early_rvalid got %b exp 000", rvalid_o); end
        next_cycle();
        mem_rdata_i = 32'h000000A5;
        @(negedge clk);
        checks++; if (rvalid_o !== 3'b010) begin errors++; $display("FAIL single_rvalid got %b exp 010", rvalid_o); end
        checks++; if (rdata_o !== 32'h000000A5) begin errors++; $display("FAIL single_rdata got %h exp 000000a5", rdata_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL single_late_rvalid got %b exp 000", rvalid_o); end
    endtask

    task automatic test_round_robin();
        logic [NUM_CH-1:0] exp;
        do_reset();
        req_i = '1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = FIXED ? 3'b001 : (3'b001 << (k % NUM_CH));
            checks++; if (gnt_o !== exp) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt_o, exp); end
            if (k > 0) begin
                checks++; if (mem_en_o !== 1'b1) begin errors++; $display("FAIL rr_bubble[%0d] got mem_en=%b exp 1", k, mem_en_o); end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lock_burst();
        logic [NUM_CH-1:0] exp;
        do_reset();
        set_ch(0, 1'b0, 1'b1, 16'h0100, '0);
        set_ch(2, 1'b0, 1'b0, 16'h0200, '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = (k < MAX_LOCK) ? 3'b001 : 3'b100;
            checks++; if (gnt_o !== exp) begin errors++; $display("FAIL lock_burst_gnt[%0d] got %b exp %b", k, gnt_o, exp); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_mixed();
        do_reset();
        set_ch(0, 1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF);
        set_ch(1, 1'b0, 1'b0, 16'h0020, '0);
        mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL mixed_gnt0 got %b exp 001", gnt_o); end
        next_cycle();
        req_i[0] = 1'b0;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL mixed_gnt1 got %b exp 010", gnt_o); end
        checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 16'h0010 || mem_wdata_o !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL mixed_write got en=%b we=%b addr=%h wd=%h exp 1 1 0010 deadbeef", mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++; if (mem_en_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 16'h0020) begin
            errors++; $display("FAIL mixed_read got en=%b we=%b addr=%h exp 1 0 0020", mem_en_o, mem_we_o, mem_addr_o); end
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL mixed_rv_a2 got %b exp 000", rvalid_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL mixed_no_write_rv got %b exp 000", rvalid_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (rvalid_o !== 3'b010 || rdata_o !== 32'h1234_5678) begin
            errors++; $display("FAIL mixed_rv got %b/%h exp 010/12345678", rvalid_o, rdata_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL mixed_rv_after got %b exp 000", rvalid_o); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_ch(0, 1'b0, 1'b0, 16'h0080, '0);
        @(negedge clk);
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL rmid_gnt got %b exp 001", gnt_o); end
        next_cycle();
        idle_inputs();
        rst = 1'b1;
        req_i[1] = 1'b1;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL rmid_gnt_in_rst got %b exp 000", gnt_o); end
        checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL rmid_mem_en got %b exp 0", mem_en_o); end
        for (int k = 2; k <= 4; k++) begin
            next_cycle();
            if (k == 3) begin
                rst = 1'b0;
                idle_inputs();
            end
            @(negedge clk);
            checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL rmid_rvalid[N+%0d] got %b exp 000", k, rvalid_o); end
        end
        next_cycle();
        req_i = '1;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL rmid_ptr_reset got %b exp 001", gnt_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lock_drop();
        do_reset();
        set_ch(0, 1'b0, 1'b1, 16'h0300, '0);
        set_ch(1, 1'b0, 1'b0, 16'h0400, '0);
        @(negedge clk);
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL drop_gnt1 got %b exp 001", gnt_o); end
        next_cycle();
        lock_i[0] = 1'b0;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL drop_gnt2 got %b exp 001", gnt_o); end
        next_cycle();
        req_i[0] = 1'b0;
        @(negedge clk);
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL drop_gnt3 got %b exp 010", gnt_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_random();
        bit               pend [NUM_CH];
        bit               p_we [NUM_CH];
        bit               p_lk [NUM_CH];
        logic [ADDR_W-1:0] p_addr [NUM_CH];
        logic [DATA_W-1:0] p_data [NUM_CH];
        int exp_rv [N_RAND + 8];
        int m_ptr, m_lk, m_cnt, m_excl, new_excl, win, c;
        bit m_locked;
        int prev_win;
        bit prev_we;
        logic [ADDR_W-1:0] prev_addr;
        logic [DATA_W-1:0] prev_data;
        logic [NUM_CH-1:0] exp_gnt, exp_rvv;

        for (int i = 0; i < N_RAND + 8; i++) exp_rv[i] = -1;
        for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b0;
        m_ptr = 0; m_locked = 1'b0; m_lk = 0; m_cnt = 0; m_excl = -1;
        prev_win = -1; prev_we = 1'b0; prev_addr = '0; prev_data = '0;
        do_reset();

        for (int t = 0; t < N_RAND; t++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 8) begin
                    pend[i]   = 1'b1;
                    p_we[i]   = ($urandom_range(0, 2) == 0);
                    p_lk[i]   = ($urandom_range(0, 3) != 0);
                    p_addr[i] = ADDR_W'($urandom_range(0, 65535));
                    p_data[i] = $urandom;
                end
                req_i[i]  = pend[i];
                we_i[i]   = pend[i] & p_we[i];
                lock_i[i] = pend[i] & p_lk[i];
                addr_i[i*ADDR_W +: ADDR_W]  = p_addr[i];
                wdata_i[i*DATA_W +: DATA_W] = p_data[i];
            end
            mem_rdata_i = $urandom;
            @(negedge clk);

            win = -1;
            if (m_locked) begin
                if (pend[m_lk]) win = m_lk;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    c = FIXED ? i : (m_ptr + i) % NUM_CH;
                    if (win < 0 && pend[c] && c != m_excl) win = c;
                end
            end
            exp_gnt = (win >= 0) ? (3'b001 << win) : 3'b000;
            exp_rvv = (exp_rv[t] >= 0) ? (3'b001 << exp_rv[t]) : 3'b000;

            checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rand_gnt t=%0d got %b exp %b", t, gnt_o, exp_gnt); end
            checks++; if (mem_en_o !== (prev_win >= 0) || mem_we_o !== (prev_win >= 0 && prev_we)) begin
                errors++; $display("FAIL rand_mem_ctl t=%0d got en=%b we=%b exp en=%b we=%b", t, mem_en_o, mem_we_o, prev_win >= 0, prev_win >= 0 && prev_we); end
            if (prev_win >= 0) begin
                checks++; if (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
                    errors++; $display("FAIL rand_mem_payload t=%0d got %h/%h exp %h/%h", t, mem_addr_o, mem_wdata_o, prev_addr, prev_data); end
            end
            checks++; if (rvalid_o !== exp_rvv) begin errors++; $display("FAIL rand_rvalid t=%0d got %b exp %b", t, rvalid_o, exp_rvv); end
            if (exp_rv[t] >= 0) begin
                checks++; if (rdata_o !== mem_rdata_i) begin errors++; $display("FAIL rand_rdata t=%0d got %h exp %h", t, rdata_o, mem_rdata_i); end
            end

            new_excl = -1;
            if (win >= 0) m_ptr = (win + 1) % NUM_CH;
            if (!m_locked) begin
                if (win >= 0 && p_lk[win]) begin
                    m_locked = 1'b1; m_lk = win; m_cnt = 1;
                end
            end else if (win < 0 || !p_lk[win]) begin
                m_locked = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt >= MAX_LOCK) begin
                    m_locked = 1'b0;
                    if (FIXED) new_excl = m_lk;
                end
            end
            m_excl = new_excl;

            prev_win = win;
            if (win >= 0) begin
                prev_we   = p_we[win];
                prev_addr = p_addr[win];
                prev_data = p_data[win];
                if (!p_we[win]) exp_rv[t + 1 + MEM_LAT] = win;
                pend[win] = 1'b0;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_mixed();
        test_reset_midflight();
        test_lock_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
